// File: rtl/quadrature_counter_pkg.sv
// Shared Gray-code states and transition classification for the quadrature decoder.
// Pure definitions: no clocked logic, no latency, no flow control.
package quadrature_counter_pkg;

  localparam logic [1:0] GRAY_S0 = 2'b00;
  localparam logic [1:0] GRAY_S1 = 2'b01;
  localparam logic [1:0] GRAY_S2 = 2'b11;
  localparam logic [1:0] GRAY_S3 = 2'b10;

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_UP      = 2'd1,
    TR_DOWN    = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  function automatic logic [1:0] gray_next_up(input logic [1:0] s);
    case (s)
      GRAY_S0: return GRAY_S1;
      GRAY_S1: return GRAY_S2;
      GRAY_S2: return GRAY_S3;
      default: return GRAY_S0;
    endcase
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    if (prev == cur)
      return TR_NONE;
    else if ((prev ^ cur) == 2'b11)
      return TR_ILLEGAL;
    else if (cur == gray_next_up(prev))
      return TR_UP;
    else
      return TR_DOWN;
  endfunction

endpackage

// File: rtl/quadrature_filter.sv
// Synchroniser plus glitch filter for one raw encoder line.
// Latency SYNC_STAGES+FILTER_LEN cycles; no backpressure, pulses shorter than FILTER_LEN are dropped.
module quadrature_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filtered <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // Any return to agreement restarts the qualification count.
      if (sync_s == filtered) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filtered <= sync_s;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrature_counter.sv
// Quadrature decoder: filtered A/B to saturating detent position, direction, windowed speed and error flag.
// Outputs follow a clean input change by SYNC_STAGES+FILTER_LEN+1 cycles; no backpressure, inputs are free-running.
module quadrature_counter
  import quadrature_counter_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int FILTER_LEN       = 4,
  parameter int EDGES_PER_DETENT = 4,
  parameter int COUNT_MAX        = 27,
  parameter int COUNT_WIDTH      = 8,
  parameter int WINDOW_LOG2      = 16,
  parameter int SPEED_WIDTH      = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   A,
  input  logic                   B,
  input  logic                   CLEAR,
  output logic [COUNT_WIDTH-1:0] COUNT,
  output logic                   STEP,
  output logic                   DIRECTION,
  output logic [SPEED_WIDTH-1:0] SPEED,
  output logic                   ERROR
);

  localparam int SHIFT     = (EDGES_PER_DETENT == 4) ? 2 : (EDGES_PER_DETENT == 2) ? 1 : 0;
  localparam int POS_MAX   = COUNT_MAX * EDGES_PER_DETENT;
  localparam int POS_W     = $clog2(POS_MAX + 1);
  localparam int GUARD_LEN = SYNC_STAGES + FILTER_LEN + 1;
  localparam int GUARD_W   = $clog2(GUARD_LEN + 1);

  logic                   fa, fb;
  logic [1:0]             cur_ab, prev_ab;
  logic [GUARD_W-1:0]     guard_q;
  logic                   guard_on;
  trans_t                 tr;
  logic                   edge_up, edge_dn, edge_vld;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [WINDOW_LOG2-1:0] win_q;
  logic                   win_wrap;
  logic [SPEED_WIDTH-1:0] acc_q, acc_d;

  quadrature_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter_a (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .raw      (A),
    .filtered (fa)
  );

  quadrature_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter_b (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .raw      (B),
    .filtered (fb)
  );

  assign cur_ab   = {fa, fb};
  assign guard_on = (guard_q != GUARD_W'(GUARD_LEN));
  assign win_wrap = &win_q;

  // While the guard is armed prev_ab still follows cur_ab, so an idle nonzero level is absorbed silently.
  always_comb begin
    tr = TR_NONE;
    if (!guard_on)
      tr = classify(prev_ab, cur_ab);
  end

  assign edge_up  = (tr == TR_UP);
  assign edge_dn  = (tr == TR_DOWN);
  assign edge_vld = edge_up | edge_dn;

  always_comb begin
    pos_d = pos_q;
    if (CLEAR)
      pos_d = '0;
    else if (edge_up && (pos_q != POS_W'(POS_MAX)))
      pos_d = pos_q + 1'b1;
    else if (edge_dn && (pos_q != '0))
      pos_d = pos_q - 1'b1;
  end

  assign count_d = COUNT_WIDTH'(pos_d >> SHIFT);

  // Edges ignored at a position bound still contribute to speed.
  always_comb begin
    acc_d = acc_q;
    if (win_wrap)
      acc_d = edge_vld ? SPEED_WIDTH'(1) : '0;
    else if (edge_vld && !(&acc_q))
      acc_d = acc_q + 1'b1;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      prev_ab   <= 2'b00;
      guard_q   <= '0;
      pos_q     <= '0;
      COUNT     <= '0;
      STEP      <= 1'b0;
      DIRECTION <= 1'b0;
      ERROR     <= 1'b0;
      win_q     <= '0;
      acc_q     <= '0;
      SPEED     <= '0;
    end else begin
      prev_ab <= cur_ab;
      if (guard_on)
        guard_q <= guard_q + 1'b1;
      pos_q <= pos_d;
      COUNT <= count_d;
      STEP  <= (count_d != COUNT);
      if (edge_vld)
        DIRECTION <= edge_up;
      ERROR <= (tr == TR_ILLEGAL);
      win_q <= win_q + 1'b1;
      acc_q <= acc_d;
      if (win_wrap)
        SPEED <= acc_q;
    end
  end

endmodule

// File: doc/quadrature_counter.md
# quadrature_counter

Parametrised quadrature encoder front end for the pong paddle inputs. It synchronises and glitch-filters the raw A/B encoder lines, decodes Gray-code transitions, and keeps a saturating position in detents (0..COUNT_MAX). It also measures rotation speed over a fixed window and flags illegal double transitions. The paddle logic uses its outputs directly, with no external counter.

## Interface
- SYNC_STAGES, 2: synchroniser flops per input line (≥2)
- FILTER_LEN, 4: consecutive cycles a synchronised line must differ from its filtered value before the filtered value follows (≥1)
- EDGES_PER_DETENT, 4: valid edges per detent; 1, 2 or 4 only
- COUNT_MAX, 27: highest detent value
- COUNT_WIDTH, 8: width of COUNT; must hold COUNT_MAX
- WINDOW_LOG2, 16: speed window is 2^WINDOW_LOG2 cycles
- SPEED_WIDTH, 4: width of SPEED
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- A  in  1  raw encoder channel A (asynchronous)
- B  in  1  raw encoder channel B (asynchronous)
- CLEAR  in  1  synchronous; zero the position
- COUNT  out  COUNT_WIDTH  current position in detents
- STEP  out  1  one-cycle pulse when COUNT changes
- DIRECTION  out  1  direction of the last valid edge; 1 = up
- SPEED  out  SPEED_WIDTH  valid edges counted in the last completed window, saturating
- ERROR  out  1  one-cycle pulse on an illegal transition

## Operation
- Each line has its own path: SYNC_STAGES flops, then a filter. The filter compares the synchronised value s with the filtered value f.
  - While s == f, the filter counter is held at 0.
  - While s != f, the counter increments each cycle. When it reaches FILTER_LEN-1, f <= s and the counter returns to 0.
  - A mismatch that disappears before then resets the counter, so the glitch is rejected.
- Decode compares the filtered pair {fA,fB} against the registered previous pair, one cycle behind.
  - Up sequence: 00→01→11→10→00.
  - Down sequence: the reverse.
  - No change: nothing happens.
  - Both bits changed: ERROR pulses. Position, DIRECTION and the speed count are unchanged.
- The position register pos has range 0..COUNT_MAX*EDGES_PER_DETENT.
  - An up edge increments pos unless it is already at the maximum.
  - A down edge decrements pos unless it is 0.
  - At either bound the edge is ignored, but DIRECTION still updates.
- COUNT = pos >> log2(EDGES_PER_DETENT), taken from a register.
- STEP pulses in the cycle COUNT takes a new value.
- CLEAR sets pos to 0. If CLEAR and a valid edge occur in the same cycle, CLEAR wins; the edge still updates DIRECTION and the speed count. STEP pulses if COUNT was nonzero.
- Speed measurement:
  - A free-running window counter of WINDOW_LOG2 bits runs alongside an edge accumulator.
  - Every valid edge adds 1 to the accumulator, saturating at all-ones in SPEED_WIDTH bits. Edges ignored at a bound still count.
  - When the window counter wraps to 0, SPEED <= accumulator and the accumulator restarts. An edge in that same cycle counts as 1 for the new window.
- Startup guard: for SYNC_STAGES+FILTER_LEN+1 cycles after reset deasserts, decode is suppressed and the previous pair tracks the filtered pair. A nonzero idle input level therefore produces neither counts nor ERROR.

## Timing
- Reset values: COUNT 0, STEP 0, DIRECTION 0, SPEED 0, ERROR 0. Synchronisers, filters, previous pair, pos, filter counters, window counter and accumulator are all 0. The startup guard is armed.
- Reset asserted mid-operation clears everything immediately. No partial window is reported.
- Latency, with a stable input change applied before clock edge 0:
  - f changes at edge SYNC_STAGES+FILTER_LEN.
  - pos, COUNT, DIRECTION, ERROR and STEP update at edge SYNC_STAGES+FILTER_LEN+1.
  - With default parameters this is 7 cycles.
- Rate limit: at most one valid edge per FILTER_LEN cycles per line. Faster input is rejected as glitch.
- SPEED updates exactly once per 2^WINDOW_LOG2 cycles and holds its value between updates.

## Structure
- The shared package/header holds:
  - the Gray-state constants (00, 01, 11, 10);
  - the transition-classification codes: NONE, UP, DOWN, ILLEGAL.
- One natural sub-module, quadrature_filter: synchroniser plus glitch filter for a single line, instantiated twice with SYNC_STAGES and FILTER_LEN.
- Decode, position, speed and the startup guard live in the top level.

## Test plan
- Defaults; after the startup guard, drive 8 full up cycles (32 edges) spaced 10 cycles apart -> COUNT 8, 8 STEP pulses, DIRECTION 1, ERROR never asserted; each update lands 7 cycles after the input change.
- Up to COUNT 27, then 8 more up edges -> COUNT stays 27, no STEP; then 4 down edges -> COUNT 26, DIRECTION 0.
- Pulse A high for 3 cycles (FILTER_LEN=4) -> no change anywhere; hold for 4 cycles -> one valid edge.
- From state 00, drive A and B high in the same cycle -> one ERROR pulse, COUNT and DIRECTION unchanged. Hold A=B=1 across reset deassertion -> no ERROR, COUNT 0.
- WINDOW_LOG2=6, 5 valid edges in one window -> SPEED 5 at the next wrap; 20 edges -> SPEED 15 (saturated); an idle window -> SPEED 0.
- CLEAR asserted in the same cycle as a valid up edge at COUNT 10 -> COUNT 0, STEP pulses, DIRECTION 1. RESET asserted mid-window -> all outputs 0 on the next cycle.
